// File: rtl/unsigned_array_multiplier_pipelined_if.sv
`default_nettype none
// ============================================================================
// Module      : unsigned_array_multiplier_pipelined_if
// Description : Operand/result handshake bundle for the pipelined multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface unsigned_array_multiplier_pipelined_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                    Clear_In;
  logic                    Data_Valid_In;
  logic                    Data_Ready_Out;
  logic [DATA_WIDTH-1:0]   Data_A_In;
  logic [DATA_WIDTH-1:0]   Data_B_In;
  logic                    Result_Valid_Out;
  logic                    Result_Ready_In;
  logic [2*DATA_WIDTH-1:0] Multiplied_Result_Out;
  logic                    Busy_Out;

  modport master (
    output Clear_In, Data_Valid_In, Data_A_In, Data_B_In, Result_Ready_In,
    input  Data_Ready_Out, Result_Valid_Out, Multiplied_Result_Out, Busy_Out
  );

  modport slave (
    input  Clear_In, Data_Valid_In, Data_A_In, Data_B_In, Result_Ready_In,
    output Data_Ready_Out, Result_Valid_Out, Multiplied_Result_Out, Busy_Out
  );
endinterface
`default_nettype wire

// File: rtl/unsigned_array_multiplier_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : unsigned_array_multiplier_pipelined
// Description : Streaming unsigned multiplier; partial products and each
//               adder-tree level are registered, one product per cycle.
//               UNSIGNED_MULT_OUTPUT_REG_EN adds one output register stage.
// Revision    : 1.0 - initial release
// ============================================================================
module unsigned_array_multiplier_pipelined #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                 Clk_In,
  input  logic                                 Reset_n_In,
  unsigned_array_multiplier_pipelined_if.slave bus
);

  localparam int c_PROD_W = 2 * DATA_WIDTH;
  localparam int c_TREE_K = $clog2(DATA_WIDTH);
  localparam int c_NODES  = 2 * DATA_WIDTH - 1;
`ifdef UNSIGNED_MULT_OUTPUT_REG_EN
  localparam int c_STAGES = c_TREE_K + 2;
`else
  localparam int c_STAGES = c_TREE_K + 1;
`endif

  logic [c_STAGES-1:0] r_valid;
  logic [c_PROD_W-1:0] r_node [c_NODES];
  logic [c_PROD_W-1:0] w_product;
  logic                w_advance;

  assign w_advance                 = !r_valid[c_STAGES-1] || bus.Result_Ready_In;
  assign bus.Data_Ready_Out        = w_advance;
  assign bus.Result_Valid_Out      = r_valid[c_STAGES-1];
  assign bus.Busy_Out              = |r_valid;
  assign bus.Multiplied_Result_Out = w_product;

  // Clear beats both advance and a simultaneous accept.
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      r_valid <= '0;
    end else if (bus.Clear_In) begin
      r_valid <= '0;
    end else if (w_advance) begin
      r_valid <= {r_valid[c_STAGES-2:0], bus.Data_Valid_In};
    end
  end

  // Complete binary tree in heap order: leaves DATA_WIDTH-1.. hold the
  // partial products, node n sums children 2n+1/2n+2, root is node 0.
  // Registering every node makes each tree level its own pipeline stage.
  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      for (int n = 0; n < c_NODES; n++) begin
        r_node[n] <= '0;
      end
    end else if (w_advance) begin
      for (int n = 0; n < DATA_WIDTH - 1; n++) begin
        r_node[n] <= r_node[2*n+1] + r_node[2*n+2];
      end
      for (int i = 0; i < DATA_WIDTH; i++) begin
        r_node[DATA_WIDTH-1+i] <= bus.Data_B_In[i] ?
                                  (c_PROD_W'(bus.Data_A_In) << i) : '0;
      end
    end
  end

`ifdef UNSIGNED_MULT_OUTPUT_REG_EN
  logic [c_PROD_W-1:0] r_out;

  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      r_out <= '0;
    end else if (w_advance) begin
      r_out <= r_node[0];
    end
  end

  assign w_product = r_out;
`else
  assign w_product = r_node[0];
`endif

endmodule
`default_nettype wire

// File: doc/unsigned_array_multiplier_pipelined.md
# unsigned_array_multiplier_pipelined

Parametrised, fully pipelined unsigned array multiplier with valid/ready handshakes on both sides. It multiplies two DATA_WIDTH-bit operands into a 2·DATA_WIDTH-bit product. The partial-product adder tree is split into one registered stage per tree level, so the block sustains one product per cycle. It sits in the Arithmetic_and_Logic_Modules datapath library as the streaming successor of the 8-bit combinational array multiplier.

## Interface
- DATA_WIDTH, 8, operand width; legal values 4, 8, 16, 32 (power of two). Product width P = 2·DATA_WIDTH.
- Clk_In  input  1  clock; all state changes on rising edge.
- Reset_n_In  input  1  asynchronous, active-low reset.
- Clear_In  input  1  synchronous flush of all in-flight operations.
- Data_Valid_In  input  1  operand pair valid.
- Data_Ready_Out  output  1  block accepts operands this cycle.
- Data_A_In  input  DATA_WIDTH  multiplicand, unsigned.
- Data_B_In  input  DATA_WIDTH  multiplier, unsigned.
- Result_Valid_Out  output  1  product valid.
- Result_Ready_In  input  1  downstream accepts product.
- Multiplied_Result_Out  output  P  product A·B, unsigned, exact (no truncation).
- Busy_Out  output  1  high while any pipeline stage holds a valid operation.

## Operation
- Pipeline advance: Advance = !Result_Valid_Out || Result_Ready_In.
  - All stages shift together when Advance = 1.
  - All stages hold (data and valid bits) when Advance = 0.
  - There is no bubble collapsing.
- Data_Ready_Out = Advance, combinational. An operand pair is accepted when Data_Valid_In && Data_Ready_Out.
  - When Advance = 1 and Data_Valid_In = 0, a bubble (valid = 0) enters stage 1.
- Stage 1 registers the DATA_WIDTH partial products: PP[i] = B[i] ? (A << i) : 0, each P bits wide.
- Stages 2..K+1, with K = log2(DATA_WIDTH), each register one adder-tree level of pairwise P-bit sums: DATA_WIDTH/2, then DATA_WIDTH/4, and so on down to 1 sum.
- Every sum is computed at P bits. P bits are sufficient; no carry-out is lost.
- The final tree register drives Multiplied_Result_Out. Its valid bit drives Result_Valid_Out.
- Busy_Out = OR of all stage valid bits.
- Clear_In = 1 at a rising edge:
  - All valid bits go to 0; data registers are don't-care.
  - Clear_In has priority over Advance and over a simultaneous accept: the operand is dropped.
  - Data_Ready_Out is still driven per the Advance rule during Clear_In. Upstream must not count a transfer made in a clear cycle as accepted.
- Reset (Reset_n_In = 0), asynchronous:
  - All valid bits and all data registers go to 0 immediately.
  - Outputs: Result_Valid_Out = 0, Multiplied_Result_Out = 0, Busy_Out = 0, Data_Ready_Out = 1.
  - Reset mid-operation discards all in-flight products.
- While Result_Valid_Out = 1 and Result_Ready_In = 0, Multiplied_Result_Out is stable.
- Products leave in acceptance order. No reordering, no drops other than by Clear_In or reset.

## Timing
- Latency L = K + 1 cycles from the accepting edge to Result_Valid_Out = 1, with no stall. For DATA_WIDTH = 8, L = 4; for 16, L = 5.
- Throughput: one operation per cycle while Result_Ready_In = 1.
- Each stall cycle adds exactly one cycle to the latency of every in-flight operation.
- Capacity: at most L operations in flight.
- Critical path is one P-bit adder per stage, plus the combinational Advance/ready path.

## Configuration
- UNSIGNED_MULT_OUTPUT_REG_EN defined:
  - Adds one extra output register stage after the final tree level. It is part of the same global-stall pipeline.
  - Latency is L + 1 (5 for DATA_WIDTH = 8).
  - Reset, clear and handshake rules are unchanged.
- Undefined: latency L, and the final tree register drives the outputs directly.

## Test plan
- DATA_WIDTH = 8, reset release, accept A = 0xFF, B = 0xFF at cycle 0 with Result_Ready_In = 1 -> Result_Valid_Out = 1 with 0xFE01 at cycle 4 (cycle 5 with the macro). Busy_Out is high during cycles 1–4.
- Stream 0·0, 1·1, 3·5, 0x80·0x02 on consecutive cycles -> results 0x0000, 0x0001, 0x000F, 0x0100 on 4 consecutive cycles, in order.
- Result_Ready_In = 0 for 3 cycles while a result is valid -> Data_Ready_Out = 0, output held at its value, no loss. After release, the remaining results follow back-to-back.
- Two operations in flight, then Clear_In pulse together with a new accept -> no Result_Valid_Out afterwards, Busy_Out = 0 the cycle after the clear.
- Reset_n_In asserted asynchronously mid-stream -> all outputs at reset values before the next edge. The first post-reset operation, 7·9, returns 63 after L cycles.
- DATA_WIDTH = 16: 0xFFFF·0xFFFF -> 0xFFFE0001 after 5 cycles. DATA_WIDTH = 4: 0xF·0xF -> 0xE1 after 3 cycles.
